// File: rtl/phj_pkg.sv
// Shared types for the partition hash join datapath: packer FSM states and tag width.
package phj_pkg;

  localparam int PHJ_TAG_W = 32;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_OUT  = 2'd2
  } packer_state_t;

endpackage

// File: rtl/partition_line_packer.sv
// Packs one hash partition's tuple stream into wide lines of TUPLES_PER_LINE slots.
// Optional PACKER_STATS_EN adds wrapping input/output handshake counters.
module partition_line_packer
  import phj_pkg::*;
#(
  parameter int INPUT_SIZE      = 64,
  parameter int TUPLES_PER_LINE = 8
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  output logic                                    in_ready,
  input  logic [INPUT_SIZE-1:0]                   in,
  input  logic [PHJ_TAG_W-1:0]                    in_tag,
  input  logic                                    in_valid,
  input  logic                                    flush,
  output logic                                    flush_done,
  input  logic                                    out_ready,
  output logic [INPUT_SIZE*TUPLES_PER_LINE-1:0]   out_line,
  output logic [PHJ_TAG_W*TUPLES_PER_LINE-1:0]    out_tags,
  output logic [$clog2(TUPLES_PER_LINE+1)-1:0]    out_count,
  output logic                                    out_last,
  output logic                                    out_valid,
  output logic [1:0]                              dbg_state
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]                             stat_tuples,
  output logic [31:0]                             stat_lines
`endif
);

  localparam int N   = TUPLES_PER_LINE;
  localparam int CW  = $clog2(N);
  localparam int OCW = $clog2(N + 1);
  localparam int TW  = PHJ_TAG_W;

  // Handshakes: a transfer occurs on a rising clk edge where valid && ready.
  // A producer holding valid keeps its payload stable until that transfer.
  packer_state_t          state, state_next;
  logic [CW-1:0]          fill_cnt;
  logic                   in_fire, out_fire, out_free, line_full, load_flush;
  logic [N*INPUT_SIZE-1:0] line_next;
  logic [N*TW-1:0]        tags_next;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_free  = !out_valid || out_ready;
  assign line_full = in_fire && (fill_cnt == CW'(N - 1));
  assign dbg_state = state;

  // Slot k shows buffered data if already filled, the incoming tuple if it is
  // being written now, and zero otherwise, so stale buffer contents never leak.
  for (genvar k = 0; k < N; k++) begin : g_slot
    logic [INPUT_SIZE-1:0] data_q;
    logic [TW-1:0]         tag_q;
    logic                  held, incoming;

    assign held     = CW'(k) < fill_cnt;
    assign incoming = in_fire && (fill_cnt == CW'(k));

    always_ff @(posedge clk) begin
      if (incoming) begin
        data_q <= in;
        tag_q  <= in_tag;
      end
    end

    assign line_next[k*INPUT_SIZE +: INPUT_SIZE] = held ? data_q : (incoming ? in : '0);
    assign tags_next[k*TW +: TW]                 = held ? tag_q  : (incoming ? in_tag : '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= FILL;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:       if (flush)    state_next = FLUSH_WAIT;
      FLUSH_WAIT: if (out_free) state_next = FLUSH_OUT;
      FLUSH_OUT:  if (out_fire) state_next = FILL;
      default:                  state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    load_flush = 1'b0;
    case (state)
      FILL:       in_ready   = resetn && !((fill_cnt == CW'(N - 1)) && out_valid && !out_ready);
      FLUSH_WAIT: load_flush = out_free;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_count  <= '0;
      out_line   <= '0;
      out_tags   <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= (state == FLUSH_OUT) && out_fire;
      if (line_full) begin
        out_valid <= 1'b1;
        out_line  <= line_next;
        out_tags  <= tags_next;
        out_count <= OCW'(N);
        out_last  <= 1'b0;
        fill_cnt  <= '0;
      end else if (load_flush) begin
        out_valid <= 1'b1;
        out_line  <= line_next;
        out_tags  <= tags_next;
        out_count <= OCW'(fill_cnt);
        out_last  <= 1'b1;
        fill_cnt  <= '0;
      end else begin
        if (out_fire) out_valid <= 1'b0;
        if (in_fire)  fill_cnt  <= fill_cnt + 1'b1;
      end
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_tuples <= '0;
      stat_lines  <= '0;
    end else begin
      if (in_fire)  stat_tuples <= stat_tuples + 32'd1;
      if (out_fire) stat_lines  <= stat_lines + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_partition_line_packer.sv
// Bench for partition_line_packer (N=8, 64-bit tuples); builds with or without PACKER_STATS_EN.
module tb_partition_line_packer;
  import phj_pkg::*;

  localparam int W  = 64;
  localparam int N  = 8;
  localparam int TW = 32;
  localparam int LW = W * N;
  localparam int GW = TW * N;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [TW-1:0] in_tag;
  logic          in_valid;
  logic          flush;
  logic          flush_done;
  logic          out_ready;
  logic [LW-1:0] out_line;
  logic [GW-1:0] out_tags;
  logic [3:0]    out_count;
  logic          out_last;
  logic          out_valid;
  logic [1:0]    dbg_state;
`ifdef PACKER_STATS_EN
  logic [31:0]   stat_tuples;
  logic [31:0]   stat_lines;
`endif

  always #5 clk = ~clk;

  partition_line_packer #(.INPUT_SIZE(W), .TUPLES_PER_LINE(N)) dut (
    .clk(clk), .resetn(resetn), .in_ready(in_ready), .in(in_data), .in_tag(in_tag),
    .in_valid(in_valid), .flush(flush), .flush_done(flush_done), .out_ready(out_ready),
    .out_line(out_line), .out_tags(out_tags), .out_count(out_count), .out_last(out_last),
    .out_valid(out_valid), .dbg_state(dbg_state)
`ifdef PACKER_STATS_EN
    , .stat_tuples(stat_tuples), .stat_lines(stat_lines)
`endif
  );

  typedef struct packed {
    logic [LW-1:0] line;
    logic [GW-1:0] tags;
    logic [3:0]    count;
    logic          last;
  } line_t;

  line_t         exp_q[$];
  logic [W-1:0]  pend_d[$];
  logic [TW-1:0] pend_t[$];
  line_t         mon_e;
  int            n_checks = 0;
  int            n_fail = 0;
  int            lines_seen = 0;
  int            model_lines = 0;
  logic          rand_rdy = 1'b0;
  logic          fd_pending = 1'b0;

  // Reference model: tuples queue up in arrival order; a line closes at N tuples or on flush.
  function automatic void model_close(input logic last);
    line_t l;
    l = '0;
    for (int k = 0; k < pend_d.size(); k++) begin
      l.line[k*W +: W]   = pend_d[k];
      l.tags[k*TW +: TW] = pend_t[k];
    end
    l.count = 4'(pend_d.size());
    l.last  = last;
    exp_q.push_back(l);
    model_lines++;
    pend_d.delete();
    pend_t.delete();
  endfunction

  function automatic void model_accept(input logic [W-1:0] d, input logic [TW-1:0] t);
    pend_d.push_back(d);
    pend_t.push_back(t);
    if (pend_d.size() == N) model_close(1'b0);
  endfunction

  function automatic void model_flush();
    model_close(1'b1);
  endfunction

  // Scoreboard and flush_done tracker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      fd_pending = 1'b0;
    end else begin
      n_checks++;
      if (flush_done !== fd_pending) begin
        n_fail++;
        $display("FAIL flush_done: got %b, expected %b at %0t", flush_done, fd_pending, $time);
      end
      fd_pending = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        lines_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_line: count %0d last %b, expected no line at %0t", out_count, out_last, $time);
        end else begin
          mon_e = exp_q.pop_front();
          n_checks++;
          if (out_line !== mon_e.line) begin
            n_fail++;
            $display("FAIL line_data: got %h, expected %h", out_line, mon_e.line);
          end
          n_checks++;
          if ({out_tags, out_count, out_last} !== {mon_e.tags, mon_e.count, mon_e.last}) begin
            n_fail++;
            $display("FAIL line_meta: got tags %h cnt %0d last %b, expected tags %h cnt %0d last %b",
                     out_tags, out_count, out_last, mon_e.tags, mon_e.count, mon_e.last);
          end
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t, input logic f, output int stalls);
    int guard;
    stalls = 0;
    guard = 0;
    in_data = d;
    in_tag = t;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        flush = f;
        model_accept(d, t);
        if (f) model_flush();
        break;
      end
      stalls++;
      guard++;
      if (guard > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", guard);
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic flush_only();
    flush = 1'b1;
    @(negedge clk);
    model_flush();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d lines outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    pend_d.delete();
    pend_t.delete();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_in_reset: got %b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_last, out_count, flush_done} !== 7'd0 || out_line !== '0 || out_tags !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid %b last %b cnt %0d fd %b, expected all zero",
               out_valid, out_last, out_count, flush_done);
    end
    n_checks++;
    if (in_ready !== 1'b1 || dbg_state !== FILL) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready %b state %0d, expected 1 and FILL", in_ready, dbg_state);
    end
`ifdef PACKER_STATS_EN
    n_checks++;
    if (stat_tuples !== 32'd0 || stat_lines !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d, expected 0/0", stat_tuples, stat_lines);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_full_lines();
    int st, tot, base;
    logic [W-1:0] slot0;
    do_reset();
    out_ready = 1'b1;
    tot = 0;
    base = lines_seen;
    for (int i = 0; i < 16; i++) begin
      send(64'(i + 1), 32'(32'hA0 + i), 1'b0, st);
      tot += st;
      if (i == 7 || i == 15) begin
        slot0 = (i == 7) ? 64'h1 : 64'h9;
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 4'd8 || out_last !== 1'b0 || out_line[W-1:0] !== slot0) begin
          n_fail++;
          $display("FAIL full_latency: got valid %b cnt %0d last %b slot0 %h, expected 1 8 0 %h",
                   out_valid, out_count, out_last, out_line[W-1:0], slot0);
        end
      end
    end
    n_checks++;
    if (tot != 0) begin
      n_fail++;
      $display("FAIL full_throughput: got %0d stall cycles, expected 0", tot);
    end
    wait_drain();
    n_checks++;
    if (lines_seen - base != 2) begin
      n_fail++;
      $display("FAIL full_line_count: got %0d, expected 2", lines_seen - base);
    end
  endtask

  task automatic test_backpressure();
    int st, tot, base;
    do_reset();
    out_ready = 1'b0;
    tot = 0;
    base = lines_seen;
    for (int i = 0; i < 15; i++) begin
      send(64'(i + 1), 32'(32'hA0 + i), 1'b0, st);
      tot += st;
    end
    n_checks++;
    if (tot != 0) begin
      n_fail++;
      $display("FAIL bp_early_stall: got %0d stall cycles, expected 0", tot);
    end
    in_data = 64'd16;
    in_tag = 32'hAF;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_in_ready: got %b, expected 0", in_ready);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_line[W-1:0] !== 64'h1 || out_tags[TW-1:0] !== 32'hA0) begin
        n_fail++;
        $display("FAIL bp_hold: got valid %b slot0 %h tag0 %h, expected 1 1 a0",
                 out_valid, out_line[W-1:0], out_tags[TW-1:0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready %b, expected 1", in_ready);
    end
    model_accept(in_data, in_tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (lines_seen - base != 2) begin
      n_fail++;
      $display("FAIL bp_line_count: got %0d, expected 2", lines_seen - base);
    end
  endtask

  task automatic test_partial_flush();
    int st, base;
    do_reset();
    out_ready = 1'b1;
    base = lines_seen;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, $urandom, 1'b0, st);
    flush_only();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pf_wait: got valid %b in_ready %b, expected 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd3 || out_last !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pf_line: got valid %b cnt %0d last %b in_ready %b, expected 1 3 1 0",
               out_valid, out_count, out_last, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (flush_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pf_done: got %b, expected 1", flush_done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (flush_done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pf_after: got fd %b in_ready %b, expected 0 1", flush_done, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (lines_seen - base != 1) begin
      n_fail++;
      $display("FAIL pf_line_count: got %0d, expected 1", lines_seen - base);
    end
  endtask

  task automatic test_empty_flush();
    int base;
    do_reset();
    out_ready = 1'b1;
    base = lines_seen;
    flush_only();
    wait_drain();
    @(negedge clk);
    n_checks++;
    if (flush_done !== 1'b1 || lines_seen - base != 1) begin
      n_fail++;
      $display("FAIL ef_done: got fd %b lines %0d, expected 1 1", flush_done, lines_seen - base);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simul_flush();
    int st, base;
    do_reset();
    out_ready = 1'b1;
    base = lines_seen;
    for (int i = 0; i < 7; i++) send({$urandom, $urandom}, $urandom, 1'b0, st);
    send({$urandom, $urandom}, $urandom, 1'b1, st);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd8 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sf_full: got valid %b cnt %0d last %b in_ready %b, expected 1 8 0 0",
               out_valid, out_count, out_last, in_ready);
    end
    @(posedge clk); #1;
    wait_drain();
    @(negedge clk);
    n_checks++;
    if (flush_done !== 1'b1 || lines_seen - base != 2) begin
      n_fail++;
      $display("FAIL sf_done: got fd %b lines %0d, expected 1 2", flush_done, lines_seen - base);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int st, base;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send({$urandom, $urandom}, $urandom, 1'b0, st);
    do_reset();
    base = lines_seen;
    for (int i = 0; i < 8; i++) send(64'(32'hC00 + i), 32'(32'hD0 + i), 1'b0, st);
    wait_drain();
    n_checks++;
    if (lines_seen - base != 1) begin
      n_fail++;
      $display("FAIL rm_line_count: got %0d, expected 1", lines_seen - base);
    end
`ifdef PACKER_STATS_EN
    n_checks++;
    if (stat_tuples !== 32'd8 || stat_lines !== 32'd1) begin
      n_fail++;
      $display("FAIL rm_stats: got %0d/%0d, expected 8/1", stat_tuples, stat_lines);
    end
`endif
  endtask

  task automatic test_random();
    int st, base, mbase;
    do_reset();
    rand_rdy = 1'b1;
    base = lines_seen;
    mbase = model_lines;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        wait_drain();
        flush_only();
      end else begin
        send({$urandom, $urandom}, $urandom, 1'($urandom_range(0, 29) == 0), st);
      end
    end
    wait_drain();
    flush_only();
    wait_drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (lines_seen - base != model_lines - mbase) begin
      n_fail++;
      $display("FAIL rand_line_count: got %0d, expected %0d", lines_seen - base, model_lines - mbase);
    end
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_tag = '0;
    test_reset();
    test_full_lines();
    test_backpressure();
    test_partial_flush();
    test_empty_flush();
    test_simul_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
